// File: rtl/mv_fifo.sv
// mv_fifo: first-word-fall-through FIFO of signed motion-vector pairs {X,Y}.
//
// The head entry is always presented on DATA_OUT_*, together with its split
// into an integer-sample part (INT_*) and fractional-sample part (FRAC_*).
// While the FIFO is empty every data output is forced to zero, so stale
// storage contents never leak out.
//
// Ports
//   CLK            clock, all state changes on rising edge
//   RST_ASYNC_N    asynchronous active-low reset
//   CLEAR          synchronous flush (wins over WRITE_EN / READ_EN)
//   WRITE_EN       push request, DATA_IN_X / DATA_IN_Y are the payload
//   READ_EN        pop request for the head entry (ignored while empty)
//   DATA_OUT_X/Y   head entry, full precision (0 when empty)
//   INT_X/Y        head >>> FRAC_BITS (floor), FRAC_X/Y low FRAC_BITS bits
//   OUT_VALID      head present (== !EMPTY)
//   FULL, EMPTY    occupancy flags, COUNT number of stored entries
//   WR_ERR         one-cycle pulse after a rejected push

// Per-component output stage: masks the head while empty and splits it
// into integer and fractional sample parts.
module mv_fifo_lane #(
  parameter int MV_WIDTH  = 19,
  parameter int FRAC_BITS = 4
) (
  input  logic [MV_WIDTH-1:0]           head,
  input  logic                          valid,
  output logic [MV_WIDTH-1:0]           dout,
  output logic [MV_WIDTH-FRAC_BITS-1:0] int_part,
  output logic [FRAC_BITS-1:0]          frac_part
);

  always_comb begin
    dout = valid ? head : '0;
    // Taking the upper bits of a two's-complement value is an arithmetic
    // shift with floor rounding, so int*2^F + frac reconstructs dout exactly.
    int_part  = dout[MV_WIDTH-1:FRAC_BITS];
    frac_part = dout[FRAC_BITS-1:0];
  end

endmodule

module mv_fifo #(
  parameter int MV_WIDTH  = 19,
  parameter int DEPTH     = 4,
  parameter int FRAC_BITS = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST_ASYNC_N,
  input  logic                                 CLEAR,
  input  logic                                 WRITE_EN,
  input  logic signed [MV_WIDTH-1:0]           DATA_IN_X,
  input  logic signed [MV_WIDTH-1:0]           DATA_IN_Y,
  input  logic                                 READ_EN,
  output logic signed [MV_WIDTH-1:0]           DATA_OUT_X,
  output logic signed [MV_WIDTH-1:0]           DATA_OUT_Y,
  output logic signed [MV_WIDTH-FRAC_BITS-1:0] INT_X,
  output logic signed [MV_WIDTH-FRAC_BITS-1:0] INT_Y,
  output logic [FRAC_BITS-1:0]                 FRAC_X,
  output logic [FRAC_BITS-1:0]                 FRAC_Y,
  output logic                                 OUT_VALID,
  output logic                                 FULL,
  output logic                                 EMPTY,
  output logic [$clog2(DEPTH+1)-1:0]           COUNT,
  output logic                                 WR_ERR
);

  localparam int NUM_LANES = 2;                 // lane 0 = X, lane 1 = Y
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Storage is deliberately not reset; the empty mask hides it.
  logic [DEPTH-1:0][NUM_LANES-1:0][MV_WIDTH-1:0] mem_q;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          wr_err_q, wr_err_d;

  logic empty, full, pop_acc, push_acc;
  logic [NUM_LANES-1:0][MV_WIDTH-1:0]           lane_in;
  logic [NUM_LANES-1:0][MV_WIDTH-1:0]           lane_head;
  logic [NUM_LANES-1:0][MV_WIDTH-1:0]           lane_out;
  logic [NUM_LANES-1:0][MV_WIDTH-FRAC_BITS-1:0] lane_int;
  logic [NUM_LANES-1:0][FRAC_BITS-1:0]          lane_frac;

  // Flags derive straight from the count register, so they can never
  // disagree with COUNT in any cycle, including during async reset.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    // A full FIFO may still accept a push when a pop frees a slot in the
    // same cycle; an empty FIFO never pops, so push+pop while empty is a
    // plain push.
    pop_acc  = READ_EN  && !empty && !CLEAR;
    push_acc = WRITE_EN && (!full || pop_acc) && !CLEAR;
    wr_err_d = WRITE_EN && !push_acc && !CLEAR;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign lane_in[0] = DATA_IN_X;
  assign lane_in[1] = DATA_IN_Y;

  always_ff @(posedge CLK) begin
    if (push_acc) mem_q[wr_ptr_q] <= lane_in;
  end

  assign lane_head = mem_q[rd_ptr_q];

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      mv_fifo_lane #(
        .MV_WIDTH  (MV_WIDTH),
        .FRAC_BITS (FRAC_BITS)
      ) u_lane (
        .head      (lane_head[l]),
        .valid     (!empty),
        .dout      (lane_out[l]),
        .int_part  (lane_int[l]),
        .frac_part (lane_frac[l])
      );
    end
  endgenerate

  assign DATA_OUT_X = lane_out[0];
  assign DATA_OUT_Y = lane_out[1];
  assign INT_X      = lane_int[0];
  assign INT_Y      = lane_int[1];
  assign FRAC_X     = lane_frac[0];
  assign FRAC_Y     = lane_frac[1];
  assign OUT_VALID  = !empty;
  assign EMPTY      = empty;
  assign FULL       = full;
  assign COUNT      = count_q;
  assign WR_ERR     = wr_err_q;

endmodule

// File: tb/tb_mv_fifo.sv
// Testbench for mv_fifo: directed vectors, a queue-based reference model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_mv_fifo;

  localparam int MVW   = 19;
  localparam int DEP   = 4;
  localparam int FB    = 4;
  localparam int SCALE = 1 << FB;

  logic CLK;
  logic RST_ASYNC_N;
  logic CLEAR, WRITE_EN, READ_EN;
  logic signed [MVW-1:0]    DATA_IN_X, DATA_IN_Y;
  logic signed [MVW-1:0]    DATA_OUT_X, DATA_OUT_Y;
  logic signed [MVW-FB-1:0] INT_X, INT_Y;
  logic [FB-1:0]            FRAC_X, FRAC_Y;
  logic OUT_VALID, FULL, EMPTY, WR_ERR;
  logic [$clog2(DEP+1)-1:0] COUNT;

  mv_fifo #(.MV_WIDTH(MVW), .DEPTH(DEP), .FRAC_BITS(FB)) dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .CLEAR(CLEAR),
    .WRITE_EN(WRITE_EN), .DATA_IN_X(DATA_IN_X), .DATA_IN_Y(DATA_IN_Y),
    .READ_EN(READ_EN), .DATA_OUT_X(DATA_OUT_X), .DATA_OUT_Y(DATA_OUT_Y),
    .INT_X(INT_X), .INT_Y(INT_Y), .FRAC_X(FRAC_X), .FRAC_Y(FRAC_Y),
    .OUT_VALID(OUT_VALID), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
    .WR_ERR(WR_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit en_cmp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {x,y} pairs plus the write-error flag.
  int mq_x[$];
  int mq_y[$];
  bit m_err = 1'b0;

  always @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      mq_x.delete(); mq_y.delete(); m_err = 1'b0;
    end else if (CLEAR) begin
      mq_x.delete(); mq_y.delete(); m_err = 1'b0;
    end else begin
      bit pop, push;
      int in_x, in_y;
      in_x = int'(DATA_IN_X);
      in_y = int'(DATA_IN_Y);
      pop  = READ_EN && (mq_x.size() > 0);
      push = WRITE_EN && ((mq_x.size() < DEP) || pop);
      m_err = WRITE_EN && !push;
      if (pop) begin
        void'(mq_x.pop_front()); void'(mq_y.pop_front());
      end
      if (push) begin
        mq_x.push_back(in_x); mq_y.push_back(in_y);
      end
    end
  end

  function automatic int frac_of(input int v);
    return ((v % SCALE) + SCALE) % SCALE;
  endfunction

  function automatic int int_of(input int v);
    return (v - frac_of(v)) / SCALE;
  endfunction

  always @(negedge CLK) begin
    if (en_cmp) begin
      int n, hx, hy;
      n  = mq_x.size();
      hx = (n > 0) ? mq_x[0] : 0;
      hy = (n > 0) ? mq_y[0] : 0;
      chk("m_count",  int'(COUNT), n);
      chk("m_empty",  int'(EMPTY), int'(n == 0));
      chk("m_full",   int'(FULL), int'(n == DEP));
      chk("m_valid",  int'(OUT_VALID), int'(n > 0));
      chk("m_wr_err", int'(WR_ERR), int'(m_err));
      chk("m_dout_x", int'(DATA_OUT_X), hx);
      chk("m_dout_y", int'(DATA_OUT_Y), hy);
      chk("m_int_x",  int'(INT_X), int_of(hx));
      chk("m_int_y",  int'(INT_Y), int_of(hy));
      chk("m_frac_x", int'(FRAC_X), frac_of(hx));
      chk("m_frac_y", int'(FRAC_Y), frac_of(hy));
    end
  end

  // Inputs change 1 time unit after a rising edge; step returns 1 unit
  // after the edge that consumed them.
  task automatic step(input bit we, input bit re, input bit clr,
                      input int x, input int y);
    WRITE_EN  = we;
    READ_EN   = re;
    CLEAR     = clr;
    DATA_IN_X = MVW'(x);
    DATA_IN_Y = MVW'(y);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    RST_ASYNC_N = 1'b0;
    CLEAR = 0; WRITE_EN = 0; READ_EN = 0; DATA_IN_X = '0; DATA_IN_Y = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_ASYNC_N = 1'b1;
    idle();
    // Reset then idle
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_full",  int'(FULL), 0);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_valid", int'(OUT_VALID), 0);
    chk("rst_dout",  int'(DATA_OUT_X) | int'(DATA_OUT_Y) | int'(INT_X) |
                     int'(INT_Y) | int'(FRAC_X) | int'(FRAC_Y), 0);
    en_cmp = 1'b1;

    // Fractional split of a single entry, read-while-empty ignored first
    step(0, 1, 0, 0, 0);
    chk("re_empty_cnt", int'(COUNT), 0);
    step(1, 0, 0, -37, 20);
    chk("p1_valid",  int'(OUT_VALID), 1);
    chk("p1_dout_x", int'(DATA_OUT_X), -37);
    chk("p1_int_x",  int'(INT_X), -3);
    chk("p1_frac_x", int'(FRAC_X), 11);
    chk("p1_int_y",  int'(INT_Y), 1);
    chk("p1_frac_y", int'(FRAC_Y), 4);
    step(0, 1, 0, 0, 0);
    chk("p1_popped_empty", int'(EMPTY), 1);

    // Push+pop while empty: only the push happens
    step(1, 1, 0, -1, -16);
    chk("wr_rd_empty_cnt", int'(COUNT), 1);
    chk("neg_int_x", int'(INT_X), -1);
    chk("neg_frac_x", int'(FRAC_X), 15);
    chk("neg_int_y", int'(INT_Y), -1);
    chk("neg_frac_y", int'(FRAC_Y), 0);
    step(0, 1, 0, 0, 0);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) step(1, 0, 0, i, 100 + i);
    chk("fill_full",  int'(FULL), 1);
    chk("fill_count", int'(COUNT), 4);
    step(1, 0, 0, 5, 105);
    chk("ovf_err",   int'(WR_ERR), 1);
    chk("ovf_count", int'(COUNT), 4);
    idle();
    chk("ovf_err_gone", int'(WR_ERR), 0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", int'(DATA_OUT_X), i);
      step(0, 1, 0, 0, 0);
    end
    chk("drain_empty", int'(EMPTY), 1);

    // Push+pop while full, then wrapping interleave
    for (int i = 11; i <= 14; i++) step(1, 0, 0, i, -i);
    step(1, 1, 0, 9, -9);
    chk("fullpp_count", int'(COUNT), 4);
    chk("fullpp_head",  int'(DATA_OUT_X), 12);
    chk("fullpp_err",   int'(WR_ERR), 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 20 + i, -(20 + i));
    chk("wrap_head", int'(DATA_OUT_X), 26);
    chk("wrap_head_y", int'(DATA_OUT_Y), -26);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("wrap_empty", int'(EMPTY), 1);

    // Clear overrides a write, and a clear while full raises no error
    for (int i = 0; i < 3; i++) step(1, 0, 0, 40 + i, 0);
    step(1, 0, 1, 77, 77);
    chk("clr_count", int'(COUNT), 0);
    chk("clr_empty", int'(EMPTY), 1);
    idle();
    chk("clr_still_empty", int'(EMPTY), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 50 + i, 0);
    step(1, 1, 1, 99, 0);
    chk("clr_full_err", int'(WR_ERR), 0);
    chk("clr_full_cnt", int'(COUNT), 0);

    // Asynchronous reset between edges
    step(1, 0, 0, 61, 62);
    step(1, 0, 0, 63, 64);
    chk("pre_rst_count", int'(COUNT), 2);
    WRITE_EN = 0;
    #2;
    RST_ASYNC_N = 1'b0;
    #1;
    chk("arst_empty", int'(EMPTY), 1);
    chk("arst_count", int'(COUNT), 0);
    chk("arst_valid", int'(OUT_VALID), 0);
    chk("arst_dout",  int'(DATA_OUT_X) | int'(DATA_OUT_Y), 0);
    @(posedge CLK);
    #1;
    RST_ASYNC_N = 1'b1;
    step(1, 0, 0, -200, 333);
    chk("post_rst_count", int'(COUNT), 1);
    chk("post_rst_head",  int'(DATA_OUT_X), -200);
    chk("post_rst_int_x", int'(INT_X), -13);
    chk("post_rst_frac_x", int'(FRAC_X), 8);
    step(0, 1, 0, 0, 0);
    idle();

    en_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mv_fifo.md
MV_FIFO -- requirements
Module: mv_fifo

Interface
REQ-001 Parameter MV_WIDTH, default 19: signed width of each MV component (X and Y).
REQ-002 Parameter DEPTH, default 4: number of MV pairs stored; power of two, >= 2.
REQ-003 Parameter FRAC_BITS, default 4: fractional-sample bits of each component, 1..MV_WIDTH-2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  clock; all state changes on its rising edge.
REQ-006 RST_ASYNC_N  input  1  asynchronous reset, active-low.
REQ-007 CLEAR  input  1  synchronous flush of all stored entries.
REQ-008 WRITE_EN  input  1  push request.
REQ-009 DATA_IN_X, DATA_IN_Y  input  MV_WIDTH signed  MV components to push.
REQ-010 READ_EN  input  1  pop request for the head entry.
REQ-011 DATA_OUT_X, DATA_OUT_Y  output  MV_WIDTH signed  head entry, full precision.
REQ-012 INT_X, INT_Y  output  MV_WIDTH-FRAC_BITS signed  integer-sample part of head entry.
REQ-013 FRAC_X, FRAC_Y  output  FRAC_BITS unsigned  fractional-sample part of head entry.
REQ-014 OUT_VALID  output  1  head entry present (equals not EMPTY).
REQ-015 FULL, EMPTY  output  1  occupancy flags.
REQ-016 COUNT  output  clog2(DEPTH+1)  number of stored entries.
REQ-017 WR_ERR  output  1  one-cycle pulse: write rejected.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH {X,Y} pairs with write and read pointers wrapping from DEPTH-1 to 0.
REQ-019 Write accepted when WRITE_EN=1 and (FULL=0 or pop accepted same cycle); entry stored at tail, write pointer +1.
REQ-020 Pop accepted when READ_EN=1 and OUT_VALID=1; read pointer +1; READ_EN while EMPTY SHALL be ignored.
REQ-021 Outputs SHALL be first-word-fall-through: a write into an empty FIFO appears on DATA_OUT_* and OUT_VALID=1 in the cycle after the write edge.
REQ-022 WRITE_EN=1 while FULL=1 with no accepted pop: data dropped, state unchanged, WR_ERR=1 for exactly the next cycle.
REQ-023 Simultaneous accepted push and pop: COUNT unchanged, both pointers advance.
REQ-024 Simultaneous WRITE_EN and READ_EN while EMPTY: write accepted, no pop, COUNT becomes 1.
REQ-025 CLEAR=1 SHALL reset pointers and COUNT to 0 at the next edge, overriding WRITE_EN and READ_EN in that cycle; no WR_ERR generated.
REQ-026 INT_* = DATA_OUT_* arithmetic-shifted right by FRAC_BITS (floor toward minus infinity); FRAC_* = low FRAC_BITS bits of DATA_OUT_*; INT*2^FRAC_BITS + FRAC SHALL equal DATA_OUT exactly.
REQ-027 When EMPTY=1, DATA_OUT_*, INT_* and FRAC_* SHALL be 0.
REQ-028 FULL = (COUNT == DEPTH); EMPTY = (COUNT == 0); flags SHALL be registered-consistent with COUNT in the same cycle.
REQ-029 Entries SHALL be popped in exactly the order written, across any number of pointer wraps.

Reset
REQ-030 RST_ASYNC_N=0 SHALL immediately, without a clock edge, force pointers and COUNT to 0, EMPTY=1, FULL=0, OUT_VALID=0, WR_ERR=0, all data outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; first edge after deassertion behaves as from an empty FIFO.
REQ-032 Storage array contents need not be reset; they SHALL never be visible while EMPTY.

Verification (defaults MV_WIDTH=19, DEPTH=4, FRAC_BITS=4)
REQ-033 Reset then idle -> EMPTY=1, FULL=0, COUNT=0, OUT_VALID=0, all data outputs 0.
REQ-034 Push X=-37, Y=20 -> next cycle OUT_VALID=1, DATA_OUT_X=-37, INT_X=-3, FRAC_X=11, INT_Y=1, FRAC_Y=4.
REQ-035 Push 1,2,3,4 then push 5 -> FULL=1, COUNT=4, WR_ERR pulses one cycle; pops return 1,2,3,4, then EMPTY=1.
REQ-036 With FULL=1, push 9 and pop together -> COUNT stays 4, head advances; 10 interleaved push/pop values wrap pointers and pop in order.
REQ-037 COUNT=3, CLEAR=1 with WRITE_EN=1 -> next cycle COUNT=0, EMPTY=1, written value never popped.
REQ-038 COUNT=2, RST_ASYNC_N low between edges -> outputs 0 and EMPTY=1 before next rising edge.
